// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use and mfc0 bubbles, mult/div
// occupancy, branch squash and exception/eret redirect, plus a stall counter.
module hazard_ctrl #(
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regWr,
  input  logic [1:0]       ex_memtoreg,
  input  logic [2:0]       ex_cp0op,
  input  logic             mdu_start,
  input  logic             branch_taken,
  input  logic             exc_req,
  input  logic             eret,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_MDU, S_FLUSH} state_t;

  localparam logic [5:0] MCNT_INIT = 6'(MDU_LAT - 2);

  state_t     state, state_nx;
  logic [5:0] mcnt, mcnt_nx;
  logic       lu, ex_late_src, rs_hit, rt_hit, redirect;

  // Producers whose value is not available for forwarding from EX.
  assign ex_late_src = (ex_memtoreg == 2'd1) || (ex_memtoreg == 2'd2) ||
                       (ex_cp0op == 3'b001);
  assign rs_hit      = id_use_rs && (ex_rw == id_rs);
  assign rt_hit      = id_use_rt && (ex_rw == id_rt);
  assign lu          = ex_regWr && (ex_rw != 5'd0) && ex_late_src && (rs_hit || rt_hit);
  assign redirect    = exc_req || eret;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;
    state_nx    = state;
    mcnt_nx     = mcnt;

    if (redirect) begin
      // Aborts any mult/div in flight; no done pulse is produced.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_nx    = S_FLUSH;
      mcnt_nx     = '0;
    end else begin
      unique case (state)
        S_FLUSH: begin
          ifid_flush = 1'b1;
          state_nx   = S_RUN;
        end
        S_RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (mdu_start) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            mdu_busy   = 1'b1;
            state_nx   = S_MDU;
            mcnt_nx    = MCNT_INIT;
          end else if (lu) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        S_MDU: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
          mdu_busy   = 1'b1;
          if (mcnt == 6'd0) begin
            mdu_done = 1'b1;
            state_nx = S_RUN;
          end else begin
            mcnt_nx = mcnt - 6'd1;
          end
        end
        default: begin
          state_nx = S_RUN;
          mcnt_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      mcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      mcnt  <= mcnt_nx;
      if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance a (MDU_LAT=4, 32-bit counter) and
// instance b (MDU_LAT=16, 3-bit counter) share the same stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rw;
  logic       id_use_rs, id_use_rt, ex_regWr;
  logic [1:0] ex_memtoreg;
  logic [2:0] ex_cp0op;
  logic       mdu_start, branch_taken, exc_req, eret;

  logic pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a;
  logic exmem_flush_a, mdu_busy_a, mdu_done_a;
  logic [31:0] stall_cnt_a;
  logic pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b;
  logic exmem_flush_b, mdu_busy_b, mdu_done_b;
  logic [2:0] stall_cnt_b;

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, mdu_busy, mdu_done}
  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {pc_stall_a, ifid_stall_a, ifid_flush_a, idex_stall_a,
                  idex_flush_a, exmem_flush_a, mdu_busy_a, mdu_done_a};
  assign ctl_b = {pc_stall_b, ifid_stall_b, ifid_flush_b, idex_stall_b,
                  idex_flush_b, exmem_flush_b, mdu_busy_b, mdu_done_b};

  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_LU    = 8'b1100_1000;
  localparam logic [7:0] C_MDU   = 8'b1101_0010;
  localparam logic [7:0] C_DONE  = 8'b1101_0011;
  localparam logic [7:0] C_EXC   = 8'b0010_1100;
  localparam logic [7:0] C_FLUSH = 8'b0010_0000;
  localparam logic [7:0] C_BR    = 8'b0010_1000;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rw(ex_rw), .ex_regWr(ex_regWr),
    .ex_memtoreg(ex_memtoreg), .ex_cp0op(ex_cp0op), .mdu_start(mdu_start),
    .branch_taken(branch_taken), .exc_req(exc_req), .eret(eret),
    .pc_stall(pc_stall_a), .ifid_stall(ifid_stall_a), .ifid_flush(ifid_flush_a),
    .idex_stall(idex_stall_a), .idex_flush(idex_flush_a),
    .exmem_flush(exmem_flush_a), .mdu_busy(mdu_busy_a), .mdu_done(mdu_done_a),
    .stall_cnt(stall_cnt_a)
  );

  hazard_ctrl #(.MDU_LAT(16), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rw(ex_rw), .ex_regWr(ex_regWr),
    .ex_memtoreg(ex_memtoreg), .ex_cp0op(ex_cp0op), .mdu_start(mdu_start),
    .branch_taken(branch_taken), .exc_req(exc_req), .eret(eret),
    .pc_stall(pc_stall_b), .ifid_stall(ifid_stall_b), .ifid_flush(ifid_flush_b),
    .idex_stall(idex_stall_b), .idex_flush(idex_flush_b),
    .exmem_flush(exmem_flush_b), .mdu_busy(mdu_busy_b), .mdu_done(mdu_done_b),
    .stall_cnt(stall_cnt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rw = '0; ex_regWr = 1'b0; ex_memtoreg = '0; ex_cp0op = '0;
    mdu_start = 1'b0; branch_taken = 1'b0; exc_req = 1'b0; eret = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (ctl_a !== C_IDLE) begin
      n_fail++; $display("FAIL reset_ctl_a: got %b want %b", ctl_a, C_IDLE);
    end
    n_cmp++;
    if (stall_cnt_a !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt_a: got %0d want 0", stall_cnt_a);
    end
    n_cmp++;
    if (ctl_b !== C_IDLE || stall_cnt_b !== 3'd0) begin
      n_fail++; $display("FAIL reset_b: got %b/%0d want %b/0", ctl_b, stall_cnt_b, C_IDLE);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_regWr = 1'b1; ex_memtoreg = 2'd1; ex_rw = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    n_cmp++;
    if (ctl_a !== C_LU) begin
      n_fail++; $display("FAIL lu_load: got %b want %b", ctl_a, C_LU);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl_a !== C_IDLE || stall_cnt_a !== 32'd1) begin
      n_fail++; $display("FAIL lu_load_after: got %b/%0d want %b/1", ctl_a, stall_cnt_a, C_IDLE);
    end
    // ALU producer with matching register is forwarded, not stalled
    ex_regWr = 1'b1; ex_memtoreg = 2'd0; ex_rw = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
    #1;
    n_cmp++;
    if (ctl_a !== C_IDLE) begin
      n_fail++; $display("FAIL lu_alu_nostall: got %b want %b", ctl_a, C_IDLE);
    end
    // CP0 write-back source
    ex_memtoreg = 2'd2;
    #1;
    n_cmp++;
    if (ctl_a !== C_LU) begin
      n_fail++; $display("FAIL lu_cp0src: got %b want %b", ctl_a, C_LU);
    end
    // match exists but the ID instruction does not read rt
    id_use_rt = 1'b0;
    #1;
    n_cmp++;
    if (ctl_a !== C_IDLE) begin
      n_fail++; $display("FAIL lu_unused_rt: got %b want %b", ctl_a, C_IDLE);
    end
    clear_inputs();
  endtask

  task automatic test_mfc0();
    do_reset();
    ex_regWr = 1'b1; ex_cp0op = 3'b001; ex_rw = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
    #1;
    n_cmp++;
    if (ctl_a !== C_IDLE) begin
      n_fail++; $display("FAIL mfc0_r0: got %b want %b", ctl_a, C_IDLE);
    end
    ex_rw = 5'd3; id_rt = 5'd3;
    #1;
    n_cmp++;
    if (ctl_a !== C_LU) begin
      n_fail++; $display("FAIL mfc0_stall: got %b want %b", ctl_a, C_LU);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl_a !== C_IDLE || stall_cnt_a !== 32'd1) begin
      n_fail++; $display("FAIL mfc0_after: got %b/%0d want %b/1", ctl_a, stall_cnt_a, C_IDLE);
    end
  endtask

  task automatic test_mdu();
    do_reset();
    mdu_start = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (ctl_a !== ((i == 4) ? C_DONE : C_MDU)) begin
        n_fail++;
        $display("FAIL mdu_cycle%0d: got %b want %b", i, ctl_a, (i == 4) ? C_DONE : C_MDU);
      end
      tick();
      mdu_start = 1'b0;
      #1;
    end
    n_cmp++;
    if (ctl_a !== C_IDLE || stall_cnt_a !== 32'd4) begin
      n_fail++; $display("FAIL mdu_end: got %b/%0d want %b/4", ctl_a, stall_cnt_a, C_IDLE);
    end
  endtask

  task automatic test_exc_mid_mdu();
    do_reset();
    mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0;
    exc_req = 1'b1;
    #1;
    n_cmp++;
    if (ctl_a !== C_EXC) begin
      n_fail++; $display("FAIL exc_mdu: got %b want %b", ctl_a, C_EXC);
    end
    tick();
    exc_req = 1'b0;
    #1;
    n_cmp++;
    if (ctl_a !== C_FLUSH) begin
      n_fail++; $display("FAIL exc_flush: got %b want %b", ctl_a, C_FLUSH);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (ctl_a !== C_IDLE) begin
        n_fail++; $display("FAIL exc_run%0d: got %b want %b", i, ctl_a, C_IDLE);
      end
    end
    n_cmp++;
    if (stall_cnt_a !== 32'd1) begin
      n_fail++; $display("FAIL exc_cnt: got %0d want 1", stall_cnt_a);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ex_regWr = 1'b1; ex_memtoreg = 2'd1; ex_rw = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
    branch_taken = 1'b1;
    #1;
    n_cmp++;
    if (ctl_a !== C_BR) begin
      n_fail++; $display("FAIL branch_lu: got %b want %b", ctl_a, C_BR);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl_a !== C_IDLE || stall_cnt_a !== 32'd0) begin
      n_fail++; $display("FAIL branch_after: got %b/%0d want %b/0", ctl_a, stall_cnt_a, C_IDLE);
    end
    // branch while the MDU owns EX is ignored
    mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0;
    branch_taken = 1'b1;
    #1;
    n_cmp++;
    if (ctl_a !== C_MDU) begin
      n_fail++; $display("FAIL branch_in_mdu: got %b want %b", ctl_a, C_MDU);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    eret = 1'b1;
    #1;
    n_cmp++;
    if (ctl_a !== C_EXC) begin
      n_fail++; $display("FAIL eret_first: got %b want %b", ctl_a, C_EXC);
    end
    tick();
    #1;
    n_cmp++;
    if (ctl_a !== C_EXC) begin
      n_fail++; $display("FAIL eret_in_flush: got %b want %b", ctl_a, C_EXC);
    end
    tick();
    eret = 1'b0;
    #1;
    n_cmp++;
    if (ctl_a !== C_FLUSH) begin
      n_fail++; $display("FAIL eret_flush: got %b want %b", ctl_a, C_FLUSH);
    end
    tick();
    n_cmp++;
    if (ctl_a !== C_IDLE) begin
      n_fail++; $display("FAIL eret_run: got %b want %b", ctl_a, C_IDLE);
    end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    mdu_start = 1'b1;
    #1;
    for (int i = 1; i <= 16; i++) begin
      n_cmp++;
      if (ctl_b !== ((i == 16) ? C_DONE : C_MDU) || stall_cnt_b !== ((i > 8) ? 3'd7 : 3'(i - 1))) begin
        n_fail++;
        $display("FAIL sat_cycle%0d: got %b/%0d want %b/%0d", i, ctl_b, stall_cnt_b,
                 (i == 16) ? C_DONE : C_MDU, (i > 8) ? 7 : i - 1);
      end
      tick();
      mdu_start = 1'b0;
      #1;
    end
    n_cmp++;
    if (ctl_b !== C_IDLE || stall_cnt_b !== 3'd7) begin
      n_fail++; $display("FAIL sat_hold: got %b/%0d want %b/7", ctl_b, stall_cnt_b, C_IDLE);
    end
    // restart; the 6th occupancy cycle has mcnt=10
    do_reset();
    mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ctl_b !== C_MDU) begin
      n_fail++; $display("FAIL rst_pre: got %b want %b", ctl_b, C_MDU);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctl_b !== C_IDLE || stall_cnt_b !== 3'd0) begin
      n_fail++; $display("FAIL rst_in_mdu: got %b/%0d want %b/0", ctl_b, stall_cnt_b, C_IDLE);
    end
    tick();
    n_cmp++;
    if (ctl_b !== C_IDLE || stall_cnt_b !== 3'd0) begin
      n_fail++; $display("FAIL rst_stays_run: got %b/%0d want %b/0", ctl_b, stall_cnt_b, C_IDLE);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_mfc0();
    test_mdu();
    test_exc_mid_mdu();
    test_branch();
    test_back_to_back();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
